fbuff_port_sched: RTL and testbench

//  Owns write port A of full_buffer and shares it between the camera pixel stream and the ALU result stream.

---
 rtl/fbuff_port_sched_if.sv | 46 ++++
 rtl/fbuff_port_sched.sv | 166 ++++++++++++++++
 tb/tb_fbuff_port_sched.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fbuff_port_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fbuff_port_sched_if                                                        |
// | Camera, ALU, frame-buffer port A, mode control and status signals.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fbuff_port_sched_if #(
    parameter int AW         = 19,
    parameter int DW         = 12,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_lw = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]      mode_req;
    logic            vsync_cam;
    logic            cam_wen;
    logic [AW-1:0]   cam_waddr;
    logic [DW-1:0]   cam_wdata;
    logic            alu_valid;
    logic [AW-1:0]   alu_waddr;
    logic [DW-1:0]   alu_wdata;
    logic            alu_ready;
    logic            ovf_clr;
    logic            fb_wea;
    logic [AW-1:0]   fb_addra;
    logic [DW-1:0]   fb_dina;
    logic [1:0]      mode_cur;
    logic            cam_ovf;
    logic [c_lw-1:0] fifo_level;
    logic [1:0]      state_debug;

    modport master (
        output mode_req, vsync_cam, cam_wen, cam_waddr, cam_wdata,
        output alu_valid, alu_waddr, alu_wdata, ovf_clr,
        input  alu_ready, fb_wea, fb_addra, fb_dina,
        input  mode_cur, cam_ovf, fifo_level, state_debug
    );

    modport slave (
        input  mode_req, vsync_cam, cam_wen, cam_waddr, cam_wdata,
        input  alu_valid, alu_waddr, alu_wdata, ovf_clr,
        output alu_ready, fb_wea, fb_addra, fb_dina,
        output mode_cur, cam_ovf, fifo_level, state_debug
    );
endinterface
`default_nettype wire

// File: rtl/fbuff_port_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fbuff_port_sched                                                           |
// | Shares frame-buffer write port A between a camera FIFO and an ALU stream.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fbuff_port_sched #(
    parameter int AW         = 19,
    parameter int DW         = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIM = 8
) (
    input  wire logic         sys_clk,
    input  wire logic         rst,
    fbuff_port_sched_if.slave bus
);
    localparam int c_pw = $clog2(FIFO_DEPTH);
    localparam int c_lw = c_pw + 1;
    localparam int c_sw = $clog2(STARVE_LIM + 1);
    localparam int c_ew = AW + DW;

    localparam logic [c_lw-1:0] c_full_lvl   = c_lw'(FIFO_DEPTH);
    localparam logic [c_sw-1:0] c_starve_max = c_sw'(STARVE_LIM);
    localparam logic [c_pw-1:0] c_ptr_one    = c_pw'(1);
    localparam logic [c_lw-1:0] c_lvl_one    = c_lw'(1);
    localparam logic [c_sw-1:0] c_stv_one    = c_sw'(1);

    localparam logic [1:0] c_mode_pass   = 2'd0;
    localparam logic [1:0] c_mode_proc   = 2'd1;
    localparam logic [1:0] c_mode_shared = 2'd2;
    localparam logic [1:0] c_mode_rsvd   = 2'd3;

    localparam logic [1:0] c_st_run   = 2'd0;
    localparam logic [1:0] c_st_drain = 2'd1;

    logic [1:0]      r_state;
    logic [1:0]      r_mode;
    logic            r_vsync_d;
    logic [c_ew-1:0] r_mem [FIFO_DEPTH];
    logic [c_pw-1:0] r_wptr;
    logic [c_pw-1:0] r_rptr;
    logic [c_lw-1:0] r_level;
    logic [c_sw-1:0] r_starve;
    logic            r_ovf;
    logic            r_fb_wea;
    logic [AW-1:0]   r_fb_addra;
    logic [DW-1:0]   r_fb_dina;

    logic [1:0]      w_req_mode;
    logic            w_run;
    logic            w_drain;
    logic            w_empty;
    logic            w_full;
    logic            w_alu_ready;
    logic            w_alu_gnt;
    logic            w_cam_gnt;
    logic            w_cam_en;
    logic            w_push;
    logic            w_drop;
    logic            w_vsync_rise;
    logic [c_ew-1:0] w_head;

    // Reserved mode folds onto PASS so it never triggers a spurious drain.
    assign w_req_mode   = (bus.mode_req == c_mode_rsvd) ? c_mode_pass : bus.mode_req;
    assign w_run        = (r_state == c_st_run);
    assign w_drain      = (r_state == c_st_drain);
    assign w_empty      = (r_level == '0);
    assign w_full       = (r_level == c_full_lvl);
    assign w_vsync_rise = bus.vsync_cam & ~r_vsync_d;
    assign w_head       = r_mem[r_rptr];

    assign w_alu_ready = w_run & ((r_mode == c_mode_proc) |
                                  ((r_mode == c_mode_shared) & (w_empty | (r_starve == c_starve_max))));
    assign w_alu_gnt   = bus.alu_valid & w_alu_ready;
    assign w_cam_gnt   = ~w_alu_gnt & ~w_empty & ~(w_run & (r_mode == c_mode_proc));

    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign w_cam_en = bus.cam_wen & ((r_mode != c_mode_proc) | w_drain);
    assign w_push   = w_cam_en & (~w_full | w_cam_gnt);
    assign w_drop   = w_cam_en & w_full & ~w_cam_gnt;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_run;
            r_mode    <= c_mode_pass;
            r_vsync_d <= 1'b0;
        end else begin
            r_vsync_d <= bus.vsync_cam;
            case (r_state)
                c_st_run: begin
                    if (w_vsync_rise && (w_req_mode != r_mode))
                        r_state <= c_st_drain;
                end
                c_st_drain: begin
                    if (w_empty) begin
                        r_mode  <= w_req_mode;
                        r_state <= c_st_run;
                    end
                end
                default: r_state <= c_st_run;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_push)
            r_mem[r_wptr] <= {bus.cam_waddr, bus.cam_wdata};
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_starve   <= '0;
            r_ovf      <= 1'b0;
            r_fb_wea   <= 1'b0;
            r_fb_addra <= '0;
            r_fb_dina  <= '0;
        end else begin
            if (w_alu_gnt) begin
                r_fb_wea   <= 1'b1;
                r_fb_addra <= bus.alu_waddr;
                r_fb_dina  <= bus.alu_wdata;
            end else if (w_cam_gnt) begin
                r_fb_wea   <= 1'b1;
                r_fb_addra <= w_head[c_ew-1:DW];
                r_fb_dina  <= w_head[DW-1:0];
            end else begin
                r_fb_wea   <= 1'b0;
            end

            if (w_push)
                r_wptr <= r_wptr + c_ptr_one;
            if (w_cam_gnt)
                r_rptr <= r_rptr + c_ptr_one;

            case ({w_push, w_cam_gnt})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase

            if (w_alu_gnt || !bus.alu_valid)
                r_starve <= '0;
            else if (w_cam_gnt && (r_starve != c_starve_max))
                r_starve <= r_starve + c_stv_one;

            // A fresh overflow outranks a clear in the same cycle.
            if (w_drop)
                r_ovf <= 1'b1;
            else if (bus.ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign bus.alu_ready   = w_alu_ready;
    assign bus.fb_wea      = r_fb_wea;
    assign bus.fb_addra    = r_fb_addra;
    assign bus.fb_dina     = r_fb_dina;
    assign bus.mode_cur    = r_mode;
    assign bus.cam_ovf     = r_ovf;
    assign bus.fifo_level  = r_level;
    assign bus.state_debug = r_state;
endmodule
`default_nettype wire

// File: tb/tb_fbuff_port_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fbuff_port_sched                                                        |
// | Queue-based reference model plus directed scenarios for fbuff_port_sched.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fbuff_port_sched;
    localparam int AW    = 19;
    localparam int DW    = 12;
    localparam int DEPTH = 4;
    localparam int LIM   = 8;

    typedef logic [AW+DW-1:0] entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fbuff_port_sched_if #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH)) bus ();

    fbuff_port_sched #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
        .sys_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registered view of the port after the most recent edge.
    entry_t        mq[$];
    logic [1:0]    m_mode;
    bit            m_drain;
    bit            m_vprev;
    int            m_starve;
    bit            m_ovf;
    bit            m_wea;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            n_cam_wr = 0;
    int            n_alu_wr = 0;
    int            n_ready_hi = 0;
    logic [AW-1:0] last_cam_addr = '0;

    function automatic bit m_ready();
        return !m_drain && (m_mode == 2'd1 ||
               (m_mode == 2'd2 && (mq.size() == 0 || m_starve == LIM)));
    endfunction

    task automatic model_reset();
        mq.delete();
        m_mode = 2'd0; m_drain = 0; m_vprev = 0; m_starve = 0;
        m_ovf = 0; m_wea = 0; m_addr = '0; m_data = '0;
    endtask

    task automatic model_step();
        int         prev;
        bit         agnt, cgnt, en, drop;
        logic [1:0] req;
        entry_t     e;
        prev = mq.size();
        agnt = bus.alu_valid && m_ready();
        cgnt = !agnt && prev > 0 && !(!m_drain && m_mode == 2'd1);
        m_wea = agnt || cgnt;
        if (agnt) begin
            m_addr = bus.alu_waddr; m_data = bus.alu_wdata;
        end else if (cgnt) begin
            e = mq.pop_front();
            m_addr = e[AW+DW-1:DW]; m_data = e[DW-1:0];
        end
        en   = bus.cam_wen && (m_mode != 2'd1 || m_drain);
        drop = en && !(prev < DEPTH || cgnt);
        if (en && !drop) mq.push_back({bus.cam_waddr, bus.cam_wdata});
        if (drop) m_ovf = 1;
        else if (bus.ovf_clr) m_ovf = 0;
        if (agnt || !bus.alu_valid) m_starve = 0;
        else if (cgnt && m_starve < LIM) m_starve++;
        req = (bus.mode_req == 2'd3) ? 2'd0 : bus.mode_req;
        if (!m_drain) begin
            if (bus.vsync_cam && !m_vprev && req != m_mode) m_drain = 1;
        end else if (prev == 0) begin
            m_mode = req; m_drain = 0;
        end
        m_vprev = bus.vsync_cam;
    endtask

    always @(negedge clk) begin
        if (rst) model_reset();
        chk("fb_wea", bus.fb_wea, m_wea);
        if (m_wea) begin
            chk("fb_addra", bus.fb_addra, m_addr);
            chk("fb_dina", bus.fb_dina, m_data);
        end
        chk("alu_ready", bus.alu_ready, m_ready());
        chk("mode_cur", bus.mode_cur, m_mode);
        chk("cam_ovf", bus.cam_ovf, m_ovf);
        chk("fifo_level", bus.fifo_level, mq.size());
        chk("state_debug", bus.state_debug, m_drain ? 1 : 0);
        if (bus.fb_wea) begin
            if (bus.fb_addra[AW-1]) n_alu_wr++;
            else begin n_cam_wr++; last_cam_addr = bus.fb_addra; end
        end
        if (bus.alu_ready) n_ready_hi++;
        if (!rst) model_step();
    end

    int alu_idx = 0;

    task automatic set_alu();
        bus.alu_waddr = AW'(32'h40000 + alu_idx);
        bus.alu_wdata = DW'(32'h800 + alu_idx);
    endtask

    task automatic step();
        bit hs;
        @(negedge clk);
        hs = bus.alu_valid && bus.alu_ready;
        @(posedge clk);
        #1;
        if (hs) begin alu_idx++; set_alu(); end
    endtask

    task automatic change_mode(input logic [1:0] m);
        bus.mode_req = m; bus.vsync_cam = 1'b1;
        step();
        bus.vsync_cam = 1'b0;
        repeat (4) step();
        chk("mode_switch", bus.mode_cur, m);
    endtask

    task automatic stream(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            bus.cam_wen = 1'b1; bus.cam_waddr = AW'(base + i); bus.cam_wdata = DW'(i * 5 + 1);
            step();
        end
    endtask

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        int c0, a0, r0;
        bus.mode_req = 2'd0; bus.vsync_cam = 0; bus.cam_wen = 0;
        bus.cam_waddr = '0; bus.cam_wdata = '0; bus.alu_valid = 0; bus.ovf_clr = 0;
        set_alu();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fb_wea", bus.fb_wea, 0);
        chk("rst_fb_addra", bus.fb_addra, 0);
        chk("rst_fb_dina", bus.fb_dina, 0);
        chk("rst_level", bus.fifo_level, 0);
        chk("rst_alu_ready", bus.alu_ready, 0);
        chk("rst_mode", bus.mode_cur, 0);
        rst = 1'b0;
        repeat (2) step();

        // PASS: 640 back-to-back camera writes, ALU requesting but never served
        c0 = n_cam_wr; a0 = n_alu_wr; r0 = n_ready_hi;
        bus.alu_valid = 1'b1;
        for (int i = 0; i < 640; i++) begin
            bus.cam_wen = 1'b1; bus.cam_waddr = AW'(i); bus.cam_wdata = DW'(i * 7);
            step();
            if (i == 0) chk("t1_lat_edge0_wea", bus.fb_wea, 0);
            if (i == 1) begin
                chk("t1_lat_edge1_wea", bus.fb_wea, 1);
                chk("t1_first_addr", bus.fb_addra, 0);
            end
        end
        bus.cam_wen = 0; bus.alu_valid = 0;
        repeat (4) step();
        chk("t1_cam_writes", n_cam_wr - c0, 640);
        chk("t1_alu_writes", n_alu_wr - a0, 0);
        chk("t1_ready_cycles", n_ready_hi - r0, 0);
        chk("t1_last_addr", last_cam_addr, 639);

        // SHARED: 27 camera pushes with ALU always requesting -> one ALU slot per 9
        change_mode(2'd2);
        c0 = n_cam_wr; a0 = n_alu_wr;
        for (int i = 0; i < 31; i++) begin
            bus.cam_wen = (i < 27); bus.cam_waddr = AW'(1000 + i); bus.cam_wdata = DW'(i);
            bus.alu_valid = 1'b1;
            step();
            if (i == 27) begin
                chk("t2_level_e28", bus.fifo_level, 3);
                chk("t2_ovf_e28", bus.cam_ovf, 0);
            end
        end
        bus.cam_wen = 0; bus.alu_valid = 0;
        repeat (3) step();
        chk("t2_alu_writes", n_alu_wr - a0, 4);
        chk("t2_cam_writes", n_cam_wr - c0, 27);
        chk("t2_ovf_end", bus.cam_ovf, 0);

        // Overflow when starve slots outpace pops; clear, then set-beats-clear
        for (int i = 0; i < 46; i++) begin
            bus.cam_wen = 1'b1; bus.cam_waddr = AW'(2000 + i); bus.cam_wdata = DW'(i);
            bus.alu_valid = 1'b1; bus.ovf_clr = (i >= 39);
            step();
            if (i == 35) begin
                chk("t3_ovf_e36", bus.cam_ovf, 0);
                chk("t3_level_e36", bus.fifo_level, 4);
            end
            if (i == 36) begin
                chk("t3_ovf_e37", bus.cam_ovf, 1);
                chk("t3_level_e37", bus.fifo_level, 4);
            end
            if (i == 39) chk("t3_clr_e40", bus.cam_ovf, 0);
            if (i == 45) chk("t3_set_wins_e46", bus.cam_ovf, 1);
        end
        bus.cam_wen = 0; bus.alu_valid = 0; bus.ovf_clr = 1'b1;
        step();
        chk("t3_clr_final", bus.cam_ovf, 0);
        bus.ovf_clr = 0;
        repeat (6) step();
        chk("t3_drained", bus.fifo_level, 0);

        // Mode request changes mid-frame, applied at vsync after a 3-cycle drain
        for (int i = 0; i < 19; i++) begin
            bus.mode_req = (i >= 4) ? 2'd1 : 2'd2;
            bus.alu_valid = 1'b1;
            stream(1, 4000 + i);
            if (i == 9) begin
                chk("t4_no_early_mode", bus.mode_cur, 2);
                chk("t4_no_early_state", bus.state_debug, 0);
            end
        end
        chk("t4_level_pre", bus.fifo_level, 3);
        bus.cam_wen = 0; bus.vsync_cam = 1'b1;
        step();
        bus.vsync_cam = 0;
        chk("t4_drain_state", bus.state_debug, 1);
        chk("t4_drain_level", bus.fifo_level, 2);
        chk("t4_drain_no_alu", bus.alu_ready, 0);
        step();
        chk("t4_drain2_level", bus.fifo_level, 1);
        step();
        chk("t4_drain3_state", bus.state_debug, 1);
        step();
        chk("t4_exit_state", bus.state_debug, 0);
        chk("t4_exit_mode", bus.mode_cur, 1);
        chk("t4_exit_ready", bus.alu_ready, 1);
        bus.cam_wen = 1'b1; bus.cam_waddr = AW'(4500);
        step();
        chk("t4_alu_wea", bus.fb_wea, 1);
        chk("t4_alu_addr_hi", bus.fb_addra[AW-1], 1);
        chk("t4_cam_ignored", bus.fifo_level, 0);
        bus.cam_wen = 0; bus.alu_valid = 0;
        step();

        // Reset during drain with two entries queued
        change_mode(2'd2);
        for (int i = 0; i < 19; i++) begin
            bus.alu_valid = 1'b1;
            stream(1, 3000 + i);
        end
        bus.cam_wen = 0; bus.vsync_cam = 1'b1; bus.mode_req = 2'd0;
        step();
        chk("t5_drain_state", bus.state_debug, 1);
        chk("t5_drain_level", bus.fifo_level, 2);
        c0 = n_cam_wr;
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_wea", bus.fb_wea, 0);
        chk("t5_rst_level", bus.fifo_level, 0);
        chk("t5_rst_mode", bus.mode_cur, 0);
        chk("t5_rst_state", bus.state_debug, 0);
        bus.vsync_cam = 0; bus.alu_valid = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) step();
        chk("t5_no_queued_write", n_cam_wr - c0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
